// File: rtl/iob_gray_counter_ud_pkg.sv
// ----------------------------------------------------------------------------
// iob_gray_counter_ud_pkg
// Shared definitions for the up/down Gray counter and its helpers.
//   dir_e : counting direction encoding (UP = 1, DOWN = 0), matching dir_i.
//   op_e  : per-cycle operation selected by the load/enable priority.
// The reset value's Gray image is derived inside the counter, where the
// counter width is known, as RST_VAL ^ (RST_VAL >> 1).
// Optional build macro used by the counter: IOB_GRAY_COUNTER_UD_SAT_EN.
// ----------------------------------------------------------------------------
package iob_gray_counter_ud_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Reset is not listed here: it is applied by the registers themselves.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2
  } op_e;

endpackage

// File: rtl/iob_bin2gray.sv
// ----------------------------------------------------------------------------
// iob_bin2gray
// Combinational binary-to-Gray encoder. Shared with FIFO pointer logic.
// Parameters:
//   W      : data width (W >= 1)
// Ports:
//   bin_i  : binary input
//   gray_o : Gray-coded output, gray = {bin[W-1], bin[W-2:0] ^ bin[W-1:1]}
// ----------------------------------------------------------------------------
module iob_bin2gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  generate
    if (W == 1) begin : g_w1
      // A single bit has no neighbour to fold in.
      assign gray_o = bin_i;
    end else begin : g_wn
      assign gray_o = {bin_i[W-1], bin_i[W-2:0] ^ bin_i[W-1:1]};
    end
  endgenerate

endmodule

// File: rtl/iob_reg_re.sv
// ----------------------------------------------------------------------------
// iob_reg_re
// Register with synchronous active-high reset and load enable.
// Parameters:
//   W       : data width
//   RST_VAL : value taken on reset
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous reset, active-high, wins over en_i
//   en_i    : capture d_i when high, hold otherwise
//   d_i     : next data
//   q_o     : registered data
// ----------------------------------------------------------------------------
module iob_reg_re #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: flops are written with <= so all registers sample the same
    // pre-edge values regardless of block evaluation order.
    if (rst_i) data_q <= RST_VAL;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/iob_gray_counter_ud.sv
// ----------------------------------------------------------------------------
// iob_gray_counter_ud
// Parametrised up/down Gray-code counter with synchronous load, registered
// binary output and a one-cycle wrap pulse. Binary and Gray registers are
// both loaded from the same next-binary value, so they never disagree.
//
// Parameters:
//   W        : counter width in bits (W >= 1)
//   RST_VAL  : binary reset value; Gray reset value is RST_VAL ^ (RST_VAL>>1)
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous reset, active-high (priority over everything)
//   en_i     : count enable, one step per cycle
//   dir_i    : 1 = up, 0 = down; only meaningful when en_i = 1
//   ld_i     : synchronous load (priority over en_i)
//   ld_val_i : binary value to load
//   bin_o    : registered binary count
//   gray_o   : registered Gray count
//   wrap_o   : one-cycle pulse after a step across the all-ones/zero boundary
//   sat_o    : (IOB_GRAY_COUNTER_UD_SAT_EN only) one-cycle pulse after an
//              enabled step was blocked at a limit
//
// Build macro IOB_GRAY_COUNTER_UD_SAT_EN: when defined the counter saturates
// at 0 / all-ones instead of wrapping, wrap_o is tied 0 and sat_o is added.
// ----------------------------------------------------------------------------
module iob_gray_counter_ud
  import iob_gray_counter_ud_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] bin_o,
  output logic [W-1:0] gray_o,
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
  output logic         wrap_o,
  output logic         sat_o
`else
  output logic         wrap_o
`endif
);

  localparam logic [W-1:0] MaxVal  = '1;
  localparam logic [W-1:0] RstGray = RST_VAL ^ (RST_VAL >> 1);

  logic [W-1:0] bin_q;
  logic [W-1:0] bin_d;
  logic [W-1:0] gray_q;
  logic [W-1:0] gray_d;
  logic         flag_q;
  logic         flag_d;
  logic         upd_en;
  logic         at_limit;
  dir_e         dir;
  op_e          op;

  // Next-state: a single next-binary value feeds both registers.
  always_comb begin
    dir      = dir_e'(dir_i);
    op       = ld_i ? OP_LOAD : (en_i ? OP_STEP : OP_HOLD);
    // The step about to cross the boundary: all-ones going up, zero going down.
    at_limit = (dir == DIR_UP) ? (bin_q == MaxVal) : (bin_q == '0);
    bin_d    = bin_q;
    flag_d   = 1'b0;
    case (op)
      OP_LOAD: bin_d = ld_val_i;
      OP_STEP: begin
        // The flag means "wrapped" in modulo builds and "blocked" in
        // saturating builds; both are raised by the same boundary condition.
        flag_d = at_limit;
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
        if (!at_limit) begin
          bin_d = (dir == DIR_UP) ? bin_q + 1'b1 : bin_q - 1'b1;
        end
`else
        bin_d = (dir == DIR_UP) ? bin_q + 1'b1 : bin_q - 1'b1;
`endif
      end
      default: ;
    endcase
  end

  iob_bin2gray #(
    .W(W)
  ) u_bin2gray (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  // Value registers only need to move on a load or step; the flag must
  // clear on idle cycles, so it captures every cycle.
  assign upd_en = ld_i | en_i;

  iob_reg_re #(
    .W      (W),
    .RST_VAL(RST_VAL)
  ) u_bin_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (upd_en),
    .d_i  (bin_d),
    .q_o  (bin_q)
  );

  iob_reg_re #(
    .W      (W),
    .RST_VAL(RstGray)
  ) u_gray_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (upd_en),
    .d_i  (gray_d),
    .q_o  (gray_q)
  );

  iob_reg_re #(
    .W      (1),
    .RST_VAL(1'b0)
  ) u_flag_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (1'b1),
    .d_i  (flag_d),
    .q_o  (flag_q)
  );

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
  assign wrap_o = 1'b0;
  assign sat_o  = flag_q;
`else
  assign wrap_o = flag_q;
`endif

endmodule

// File: tb/tb_iob_gray_counter_ud.sv
// ----------------------------------------------------------------------------
// tb_iob_gray_counter_ud
// Four counter instances (W=4/RST 0, W=4/RST 3, W=1/RST 0, W=3/RST 0) share
// one stimulus stream. A reference model tracks each count as a plain
// integer with modulo (or clamped) arithmetic and derives the expected Gray
// value, wrap and saturation flags from it.
// ----------------------------------------------------------------------------
module tb_iob_gray_counter_ud;

`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int N = 4;

  int wid  [N] = '{4, 4, 1, 3};
  int rstv [N] = '{0, 3, 0, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld  = 1'b0;
  logic       en  = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] ld_val = '0;

  logic [3:0] b0, g0, b1, g1;
  logic [0:0] b2, g2;
  logic [2:0] b3, g3;
  logic       wrap_a [N];
  logic [3:0] bin_a  [N];
  logic [3:0] gray_a [N];
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
  logic       sat_a  [N];
`endif

  assign bin_a[0]  = b0;
  assign gray_a[0] = g0;
  assign bin_a[1]  = b1;
  assign gray_a[1] = g1;
  assign bin_a[2]  = {3'b000, b2};
  assign gray_a[2] = {3'b000, g2};
  assign bin_a[3]  = {1'b0, b3};
  assign gray_a[3] = {1'b0, g3};

  always #5 clk = ~clk;

  iob_gray_counter_ud #(.W(4), .RST_VAL(4'd0)) dut_w4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .ld_i(ld),
    .ld_val_i(ld_val), .bin_o(b0), .gray_o(g0),
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
    .sat_o(sat_a[0]),
`endif
    .wrap_o(wrap_a[0]));

  iob_gray_counter_ud #(.W(4), .RST_VAL(4'd3)) dut_w4r3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .ld_i(ld),
    .ld_val_i(ld_val), .bin_o(b1), .gray_o(g1),
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
    .sat_o(sat_a[1]),
`endif
    .wrap_o(wrap_a[1]));

  iob_gray_counter_ud #(.W(1), .RST_VAL(1'b0)) dut_w1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .ld_i(ld),
    .ld_val_i(ld_val[0:0]), .bin_o(b2), .gray_o(g2),
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
    .sat_o(sat_a[2]),
`endif
    .wrap_o(wrap_a[2]));

  iob_gray_counter_ud #(.W(3), .RST_VAL(3'd0)) dut_w3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .ld_i(ld),
    .ld_val_i(ld_val[2:0]), .bin_o(b3), .gray_o(g3),
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
    .sat_o(sat_a[3]),
`endif
    .wrap_o(wrap_a[3]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: integer count and last-cycle boundary flag.
  int m_bin  [N];
  bit m_flag [N];

  function automatic int gray_of(input int x);
    return x ^ (x >> 1);
  endfunction

  // Apply one cycle of stimulus, advance the model, compare every instance.
  task automatic cyc(input bit r, input bit l, input bit e, input bit d, input logic [3:0] v);
    rst = r; ld = l; en = e; dir = d; ld_val = v;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      int  lim  = (1 << wid[i]);
      int  t;
      int  prev_g = gray_of(m_bin[i]);
      bit  stepped = 1'b0;
      if (r) begin
        m_bin[i] = rstv[i]; m_flag[i] = 1'b0;
      end else if (l) begin
        m_bin[i] = int'(v) % lim; m_flag[i] = 1'b0;
      end else if (e) begin
        t = m_bin[i] + (d ? 1 : -1);
        if (t < 0 || t >= lim) begin
          m_flag[i] = 1'b1;
          if (!SAT) begin
            m_bin[i] = (t + lim) % lim;
            stepped = 1'b1;
          end
        end else begin
          m_bin[i] = t; m_flag[i] = 1'b0; stepped = 1'b1;
        end
      end else begin
        m_flag[i] = 1'b0;
      end
      check($sformatf("bin[%0d]", i),  bin_a[i],  m_bin[i]);
      check($sformatf("gray[%0d]", i), gray_a[i], gray_of(m_bin[i]));
      check($sformatf("wrap[%0d]", i), wrap_a[i], SAT ? 0 : m_flag[i]);
`ifdef IOB_GRAY_COUNTER_UD_SAT_EN
      check($sformatf("sat[%0d]", i),  sat_a[i],  m_flag[i]);
`endif
      if (stepped) check($sformatf("gray_1bit[%0d]", i), $countones(gray_a[i] ^ prev_g[3:0]), 1);
    end
  endtask

  initial begin
    // Reset and its values.
    cyc(1, 0, 0, 0, 4'd0);
    cyc(1, 0, 0, 0, 4'd0);
    check("rst_gray_r3", g1, 4'd2);

    // Full up sweep, returning to 0 with a wrap pulse on the W=4 counter.
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 1, 4'd0);

    // Down from reset wraps to all-ones.
    cyc(1, 0, 0, 0, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);
    if (!SAT) begin
      check("down_bin",  b0, 4'd15);
      check("down_gray", g0, 4'd8);
      check("down_wrap", wrap_a[0], 1'b1);
    end
    cyc(0, 0, 1, 0, 4'd0);
    if (!SAT) begin
      check("down2_bin",  b0, 4'd14);
      check("down2_gray", g0, 4'd9);
      check("down2_wrap", wrap_a[0], 1'b0);
    end

    // Load beats count.
    cyc(0, 1, 0, 0, 4'd5);
    cyc(0, 1, 1, 1, 4'd12);
    check("ld_gray", g0, 4'd10);

    // Reset beats load and count.
    cyc(0, 1, 0, 0, 4'd7);
    cyc(1, 1, 1, 1, 4'd9);

    // Direction reversal on consecutive cycles, then idle hold.
    cyc(0, 0, 1, 1, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 0, 1, 1, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 4'd0);

    // Upper limit: load 7, push up twice, then step down.
    cyc(0, 1, 0, 0, 4'd7);
    cyc(0, 0, 1, 1, 4'd0);
    cyc(0, 0, 1, 1, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 7),
          1'($urandom),
          4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
